dct_coef_pingpong_requant: RTL and testbench

//  Parametrised DCT-to-IDCT coefficient link, replacing the fixed tap din_dct = {18{dout[31]}, dout[31:18]}.
//  - Captures each N-word coefficient block from the dct stage.
//  - Requantises every word to COEF_W signed bits and sign-extends it back to DATA_W.
//  - Stores blocks in a two-bank ping-pong buffer.
//  - Replays each stored block to the idct stage through a start/reading handshake.

---
 rtl/dct_coef_pingpong_requant.sv | 201 ++++++++++++++++++++
 tb/tb_dct_coef_pingpong_requant.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dct_coef_pingpong_requant.sv
// dct_coef_pingpong_requant
//   DCT-to-IDCT coefficient link. Each BLK_SIZE-word block from the dct stage
//   is requantised to COEF_W signed bits, sign-extended back to DATA_W and
//   stored in a two-bank ping-pong buffer. It is then replayed to the idct
//   stage through a start/reading handshake.
//
//   Optional feature macro: DCT_REQUANT_ROUND_EN
//     defined   : round-half-up on the first dropped bit, saturating at the
//                 largest positive COEF_W code
//     undefined : plain truncation of in_data[DATA_W-1 -: COEF_W]
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   in_done    in   dct done, high while a block streams in
//   in_data    in   dct output word, one per clk while in_done=1
//   out_start  out  idct start request
//   out_read   in   idct reading; out_data is consumed on edges where it is 1
//   out_data   out  requantised, sign-extended coefficient
//   out_last   out  out_data holds word BLK_SIZE-1
//   ovf        out  one-cycle pulse when an incoming block is dropped
//   blk_cnt    out  count of blocks fully replayed (wraps)
module dct_coef_pingpong_requant #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned COEF_W   = 14,
    parameter int unsigned BLK_SIZE = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_done,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_start,
    input  logic              out_read,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              ovf,
    output logic [15:0]       blk_cnt
);

    localparam int unsigned IDX_W  = $clog2(BLK_SIZE);
    localparam int unsigned ADDR_W = IDX_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLK_SIZE - 1);

    typedef enum logic [1:0] {W_IDLE, W_FILL, W_HOLD} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_LOAD, R_START, R_STREAM} r_state_t;

    w_state_t          w_state;
    r_state_t          r_state;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic              wr_bank;
    logic              rd_bank;
    logic [1:0]        full;
    logic [DATA_W-1:0] mem [2*BLK_SIZE];

    // Requantiser
    logic [COEF_W-1:0] q_trunc;
    logic [COEF_W-1:0] q_sel;
    logic [DATA_W-1:0] coef;
    logic              unused_in;

    assign q_trunc   = in_data[DATA_W-1 -: COEF_W];
    assign unused_in = ^in_data;

`ifdef DCT_REQUANT_ROUND_EN
    localparam int unsigned RND_BIT = (COEF_W < DATA_W) ? DATA_W - COEF_W - 1 : 0;
    logic rnd;
    logic q_max;
    assign rnd   = (COEF_W < DATA_W) ? in_data[RND_BIT] : 1'b0;
    // Only the largest positive code can overflow when rounding up
    assign q_max = (q_trunc == {1'b0, {(COEF_W-1){1'b1}}});
    assign q_sel = (rnd && !q_max) ? q_trunc + COEF_W'(1) : q_trunc;
`else
    assign q_sel = q_trunc;
`endif

    assign coef = DATA_W'($signed(q_sel));

    // Bank handshake between the two FSMs
    logic             rd_active;
    logic             rd_free;
    logic             bank_busy;
    logic             wr_en;
    logic [IDX_W-1:0] wr_addr_idx;
    logic             wr_last;
    logic [IDX_W-1:0] rd_nxt;

    assign rd_active   = (r_state == R_START) || (r_state == R_STREAM);
    assign rd_free     = rd_active && out_read && (rd_idx == LAST_IDX);
    // A bank freed on this edge already counts as empty for a new block
    assign bank_busy   = full[wr_bank] && !(rd_free && (rd_bank == wr_bank));
    assign wr_addr_idx = (w_state == W_FILL) ? wr_idx : '0;
    assign wr_en       = in_done && (((w_state == W_IDLE) && !bank_busy) || (w_state == W_FILL));
    assign wr_last     = wr_en && (wr_addr_idx == LAST_IDX);
    assign rd_nxt      = rd_idx + IDX_W'(1);

    // Coefficient storage, both banks in one array addressed {bank, idx}
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[ADDR_W'({wr_bank, wr_addr_idx})] <= coef;
        end
    end

    // Bank full flags; set and clear never target the same bank on one edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full <= 2'b00;
        end else begin
            full <= (full | (wr_last ? 2'(2'b01 << wr_bank) : 2'b00))
                  & ~(rd_free ? 2'(2'b01 << rd_bank) : 2'b00);
        end
    end

    // Write FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_state <= W_IDLE;
            wr_idx  <= '0;
            wr_bank <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            ovf <= 1'b0;
            case (w_state)
                W_IDLE: begin
                    if (in_done) begin
                        if (bank_busy) begin
                            ovf     <= 1'b1;
                            w_state <= W_HOLD;
                        end else begin
                            wr_idx  <= IDX_W'(1);
                            w_state <= W_FILL;
                        end
                    end
                end
                W_FILL: begin
                    if (!in_done) begin
                        w_state <= W_IDLE;
                    end else if (wr_idx == LAST_IDX) begin
                        wr_bank <= ~wr_bank;
                        w_state <= W_HOLD;
                    end else begin
                        wr_idx <= wr_idx + IDX_W'(1);
                    end
                end
                W_HOLD: begin
                    if (!in_done) begin
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read FSM; R_LOAD fetches word 0 so it is valid when out_start rises
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= R_IDLE;
            rd_idx    <= '0;
            rd_bank   <= 1'b0;
            out_start <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            blk_cnt   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (full[rd_bank]) begin
                        r_state <= R_LOAD;
                    end
                end
                R_LOAD: begin
                    rd_idx    <= '0;
                    out_data  <= mem[ADDR_W'({rd_bank, {IDX_W{1'b0}}})];
                    out_last  <= 1'b0;
                    out_start <= 1'b1;
                    r_state   <= R_START;
                end
                R_START, R_STREAM: begin
                    if (out_read) begin
                        if (rd_idx == LAST_IDX) begin
                            rd_bank   <= ~rd_bank;
                            blk_cnt   <= blk_cnt + 16'd1;
                            out_start <= 1'b0;
                            out_data  <= '0;
                            out_last  <= 1'b0;
                            r_state   <= R_IDLE;
                        end else begin
                            rd_idx   <= rd_nxt;
                            out_data <= mem[ADDR_W'({rd_bank, rd_nxt})];
                            out_last <= (rd_nxt == LAST_IDX);
                            r_state  <= R_STREAM;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dct_coef_pingpong_requant.sv
// tb_dct_coef_pingpong_requant
//   Directed bench for dct_coef_pingpong_requant (DATA_W=32, COEF_W=14,
//   BLK_SIZE=64): latency, requantisation, ping-pong overflow, partial blocks,
//   read stalls with concurrent writes, and reset during replay.
module tb_dct_coef_pingpong_requant;

    localparam int N = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_done = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_start;
    logic        out_read = 1'b0;
    logic [31:0] out_data;
    logic        out_last;
    logic        ovf;
    logic [15:0] blk_cnt;

    int checks = 0;
    int errors = 0;

    dct_coef_pingpong_requant #(
        .DATA_W  (32),
        .COEF_W  (14),
        .BLK_SIZE(N)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_done  (in_done),
        .in_data  (in_data),
        .out_start(out_start),
        .out_read (out_read),
        .out_data (out_data),
        .out_last (out_last),
        .ovf      (ovf),
        .blk_cnt  (blk_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Input word generator; a few directed words sit at word 0 of some blocks
    function automatic logic [31:0] in_word(input int seed, input int k);
        logic [13:0] q;
        logic [17:0] lo;
        if (seed == 1 && k == 0) return 32'hFFFC_0000;
        if (seed == 2 && k == 0) return 32'h8000_0000;
        if (seed == 5 && k == 0) return 32'h7FFF_FFFF;
        q  = 14'(seed * 2039 + k);
        lo = (seed % 2 == 1) ? 18'(k * 4099) : 18'h0;
        return {q, lo};
    endfunction

    // Reference requantiser
    function automatic logic [31:0] exp_word(input logic [31:0] w);
        logic [13:0] q;
        q = w[31:18];
`ifdef DCT_REQUANT_ROUND_EN
        if (w[17] && (q != 14'h1FFF)) q = q + 14'd1;
`endif
        return {{18{q[13]}}, q};
    endfunction

    // Stream nwords, then one idle cycle; checks the ovf pulse on the first words
    task automatic write_block(input int seed, input int nwords, input logic exp_ovf);
        for (int k = 0; k < nwords; k++) begin
            in_done = 1'b1;
            in_data = in_word(seed, k);
            tick;
            if (k == 0) check("ovf_first", 32'(ovf), 32'(exp_ovf));
            if (k == 1) check("ovf_pulse", 32'(ovf), 32'd0);
        end
        in_done = 1'b0;
        in_data = '0;
        tick;
    endtask

    // Consume nread words; stall applies the out_read pattern 1,0,0,1
    task automatic read_block(input int seed, input logic stall, input int nread);
        int idx = 0;
        int cyc = 0;
        logic [3:0] pat = 4'b1001;
        while (idx < nread && cyc < 4 * N) begin
            check("out_start", 32'(out_start), 32'd1);
            check("out_data", out_data, exp_word(in_word(seed, idx)));
            check("out_last", 32'(out_last), 32'(idx == N - 1));
            out_read = stall ? pat[cyc % 4] : 1'b1;
            tick;
            if (out_read) idx++;
            cyc++;
        end
        out_read = 1'b0;
        check("read_budget", 32'(idx), 32'(nread));
    endtask

    task automatic wait_start;
        int n = 0;
        while (!out_start && n < 8) begin
            tick;
            n++;
        end
        check("start_wait", 32'(out_start), 32'd1);
    endtask

    initial begin
        // Reset state
        repeat (2) tick;
        check("rst_start", 32'(out_start), 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_cnt", 32'(blk_cnt), 32'd0);
        reset = 1'b1;
        tick;

        // Ramp block k<<18; out_start two edges after the last word
        write_block(0, N, 1'b0);
        check("lat_1clk", 32'(out_start), 32'd0);
        tick;
        check("lat_2clk", 32'(out_start), 32'd1);
        check("t1_word0", out_data, 32'd0);
        read_block(0, 1'b0, N);
        check("t1_start_low", 32'(out_start), 32'd0);
        check("t1_cnt", 32'(blk_cnt), 32'd1);

        // Three blocks with reader stalled: third one is dropped
        reset = 1'b0;
        tick;
        reset = 1'b1;
        tick;
        check("t3_cnt0", 32'(blk_cnt), 32'd0);
        write_block(1, N, 1'b0);
        write_block(2, N, 1'b0);
        write_block(3, N, 1'b1);
        check("t2_neg1", out_data, 32'hFFFF_FFFF);
        read_block(1, 1'b0, N);
        wait_start;
        check("t2_min", out_data, 32'hFFFF_E000);
        read_block(2, 1'b0, N);
        check("t3_cnt", 32'(blk_cnt), 32'd2);
        repeat (4) tick;
        check("t3_no_third", 32'(out_start), 32'd0);

        // Partial block is discarded
        write_block(4, 40, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("t4_no_start", 32'(out_start), 32'd0);
            tick;
        end
        write_block(4, N, 1'b0);
        wait_start;
        read_block(4, 1'b0, N);
        check("t4_cnt", 32'(blk_cnt), 32'd3);

        // Stalled replay while the other bank fills
        write_block(5, N, 1'b0);
        wait_start;
        check("t5_sat", out_data, 32'h0000_1FFF);
        fork
            read_block(5, 1'b1, N);
            write_block(6, N, 1'b0);
        join
        wait_start;
        read_block(6, 1'b0, N);
        check("t5_cnt", 32'(blk_cnt), 32'd5);

        // Reset at word 30 of a replay
        write_block(7, N, 1'b0);
        wait_start;
        read_block(7, 1'b0, 30);
        check("t6_word30", out_data, exp_word(in_word(7, 30)));
        reset = 1'b0;
        #1;
        check("t6_start", 32'(out_start), 32'd0);
        check("t6_data", out_data, 32'd0);
        check("t6_last", 32'(out_last), 32'd0);
        check("t6_cnt", 32'(blk_cnt), 32'd0);
        tick;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            check("t6_empty", 32'(out_start), 32'd0);
        end
        write_block(8, N, 1'b0);
        wait_start;
        read_block(8, 1'b0, N);
        check("t6_cnt_after", 32'(blk_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
